// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : FSM state and memory-operation types for mem_access_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_DATA   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_t;

    // A request with both strobes set is treated as a store.
    function automatic op_t decode_op(input logic re, input logic we);
        return we ? OP_STORE : (re ? OP_LOAD : OP_NONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Core-side and memory-side signal bundle of mem_access_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;

    logic [31:0] next_pc;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_re;
    logic        ls_we;
    logic        jisr;
    logic        eret;
    logic [31:0] epc;

    logic [31:0] PC;
    logic [31:0] I;
    logic        E;
    logic [31:0] ls_rdata;
    logic        misalign;
    logic        bus_err;

    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  next_pc, ls_addr, ls_wdata, ls_re, ls_we, jisr, eret, epc,
        input  mem_rdata, mem_ack,
        output PC, I, E, ls_rdata, misalign, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output next_pc, ls_addr, ls_wdata, ls_re, ls_we, jisr, eret, epc,
        output mem_rdata, mem_ack,
        input  PC, I, E, ls_rdata, misalign, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_req_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_watchdog
//  Description : Counts consecutive unanswered request cycles and flags a
//                timeout on the TIMEOUT_CYCLES-th one.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_req,
    input  wire logic i_ack,
    output logic      o_timeout
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_stall;

    assign w_stall   = i_req & ~i_ack;
    assign o_timeout = w_stall & (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || !w_stall || o_timeout) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Fetch / execute / data / commit sequencer between a core and
//                a single-port request/ack memory. Define MEM_ACCESS_TIMEOUT_EN
//                to enable the request watchdog and bus_err reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter logic [31:0] ISR_PC         = 32'h0,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_access_ctrl_if.master  bus
);

    state_t      r_state;
    state_t      w_next_state;
    op_t         r_op;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_ls_rdata;
    logic [31:0] r_ls_wdata;
    logic [29:0] r_ls_word;

    logic        w_mem_req;
    logic        w_mem_we;
    logic [29:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic        w_e;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_ls_access;
    logic        w_ls_aligned;

    assign w_ls_access  = bus.ls_re | bus.ls_we;
    assign w_ls_aligned = (bus.ls_addr[1:0] == 2'b00);
    // Gated by rst so a pending request vanishes as soon as reset is seen.
    assign w_mem_req    = ~rst & ((r_state == S_FETCH) | (r_state == S_DATA));

`ifdef MEM_ACCESS_TIMEOUT_EN
    mem_req_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_mem_req),
        .i_ack     (bus.mem_ack),
        .o_timeout (w_timeout)
    );
`else
    // No watchdog: an unanswered request waits forever.
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_pc[31:2];
        w_mem_wdata  = '0;
        w_e          = 1'b0;
        w_misalign   = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ack || w_timeout) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_e = ~rst;
                if (w_ls_access && w_ls_aligned) begin
                    w_next_state = S_DATA;
                end else begin
                    w_misalign   = ~rst & w_ls_access;
                    w_next_state = S_COMMIT;
                end
            end
            S_DATA: begin
                w_mem_addr  = r_ls_word;
                w_mem_we    = ~rst & (r_op == OP_STORE);
                w_mem_wdata = r_ls_wdata;
                if (bus.mem_ack || w_timeout) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_ls_rdata <= '0;
            r_ls_wdata <= '0;
            r_ls_word  <= '0;
            r_op       <= OP_NONE;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        r_instr <= bus.mem_rdata;
                    end else if (w_timeout) begin
                        r_instr <= '0;
                    end
                end
                S_EXEC: begin
                    r_op       <= decode_op(bus.ls_re, bus.ls_we);
                    r_ls_word  <= bus.ls_addr[31:2];
                    r_ls_wdata <= bus.ls_wdata;
                end
                S_DATA: begin
                    // A timed-out load leaves ls_rdata untouched.
                    if (bus.mem_ack && (r_op == OP_LOAD)) begin
                        r_ls_rdata <= bus.mem_rdata;
                    end
                end
                S_COMMIT: begin
                    if (bus.jisr) begin
                        r_pc <= ISR_PC;
                    end else if (bus.eret) begin
                        r_pc <= bus.epc;
                    end else begin
                        r_pc <= bus.next_pc;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    assign bus.PC        = r_pc;
    assign bus.I         = r_instr;
    assign bus.E         = w_e;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.misalign  = w_misalign;
    assign bus.bus_err   = w_timeout;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Directed self-checking bench for mem_access_ctrl; builds the
//                expected per-cycle outputs of each instruction from its
//                phase timing and compares them every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [31:0] c_RESET_PC = 32'h0;
    localparam logic [31:0] c_ISR_PC   = 32'h80;
    localparam int          c_TMO      = 16;

    typedef struct {
        logic [31:0] instr;
        int          fw;
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memword;
        int          dw;
        logic        jisr;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] npc;
        logic        spur;
    } instr_t;

    typedef struct {
        bit          chk_mem;
        bit          chk_state;
        logic        req;
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        e;
        logic        mis;
        logic        berr;
        logic [31:0] pc;
        logic [31:0] i;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .RESET_PC       (c_RESET_PC),
        .ISR_PC         (c_ISR_PC),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          n_req_seen = 0;
    int          n_we_seen  = 0;
    logic [31:0] m_pc = c_RESET_PC;
    logic [31:0] m_i  = 32'h0;
    logic [31:0] m_rd = 32'h0;
    exp_t        q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t base_exp();
        exp_t e;
        e.chk_mem   = 1'b1;
        e.chk_state = 1'b1;
        e.req       = 1'b0;
        e.we        = 1'b0;
        e.addr      = '0;
        e.wdata     = '0;
        e.e         = 1'b0;
        e.mis       = 1'b0;
        e.berr      = 1'b0;
        e.pc        = m_pc;
        e.i         = m_i;
        e.rd        = m_rd;
        return e;
    endfunction

    function automatic instr_t mk(input logic [31:0] instr, input int fw,
                                  input logic re, input logic we,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] memword, input int dw,
                                  input logic jisr, input logic eret,
                                  input logic [31:0] epc, input logic [31:0] npc,
                                  input logic spur);
        instr_t t;
        t.instr = instr; t.fw = fw; t.re = re; t.we = we; t.addr = addr;
        t.wdata = wdata; t.memword = memword; t.dw = dw; t.jisr = jisr;
        t.eret = eret; t.epc = epc; t.npc = npc; t.spur = spur;
        return t;
    endfunction

    // One instruction: fetch (fw wait cycles, <0 = never acked), one execute
    // cycle, an optional data phase (dw wait cycles), one commit cycle.
    task automatic run_instr(input instr_t t);
        exp_t e;
        int   n;
        logic acc;
        logic alig;
        acc  = t.re | t.we;
        alig = (t.addr[1:0] == 2'b00);
        n    = (t.fw < 0) ? c_TMO : t.fw + 1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) begin
                rst          = 1'b0;
                bus.next_pc  = t.npc;
                bus.ls_addr  = t.addr;
                bus.ls_wdata = t.wdata;
                bus.ls_re    = t.re;
                bus.ls_we    = t.we;
                bus.jisr     = t.jisr;
                bus.eret     = t.eret;
                bus.epc      = t.epc;
            end
            e      = base_exp();
            e.req  = 1'b1;
            e.addr = m_pc[31:2];
            e.berr = (t.fw < 0) && (c == c_TMO - 1);
            bus.mem_ack   = (c == t.fw);
            bus.mem_rdata = (c == t.fw) ? t.instr : (32'hBAD0_0000 | 32'(c));
            q.push_back(e);
        end
        m_i = (t.fw < 0) ? 32'h0 : t.instr;

        @(negedge clk);
        e     = base_exp();
        e.e   = 1'b1;
        e.mis = acc & ~alig;
        bus.mem_ack   = t.spur;
        bus.mem_rdata = 32'hFFFF_FFFF;
        q.push_back(e);

        if (acc && alig) begin
            n = (t.dw < 0) ? c_TMO : t.dw + 1;
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                e       = base_exp();
                e.req   = 1'b1;
                e.addr  = t.addr[31:2];
                e.we    = t.we;
                e.wdata = t.wdata;
                e.berr  = (t.dw < 0) && (c == c_TMO - 1);
                bus.mem_ack   = (c == t.dw);
                bus.mem_rdata = (c == t.dw) ? t.memword : (32'hBAD1_0000 | 32'(c));
                q.push_back(e);
            end
            if (!t.we && t.dw >= 0) m_rd = t.memword;
        end

        @(negedge clk);
        e = base_exp();
        bus.mem_ack   = t.spur;
        bus.mem_rdata = 32'h7777_7777;
        q.push_back(e);
        m_pc = t.jisr ? c_ISR_PC : (t.eret ? t.epc : t.npc);
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles: the first is not judged (reset not yet sampled).
    task automatic do_reset(input logic ack_in_reset);
        exp_t e;
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ack   = ack_in_reset;
        bus.mem_rdata = 32'h5A5A_5A5A;
        e             = base_exp();
        e.chk_mem     = 1'b0;
        e.chk_state   = 1'b0;
        q.push_back(e);
        m_pc = c_RESET_PC;
        m_i  = 32'h0;
        m_rd = 32'h0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        q.push_back(base_exp());
        @(posedge clk);
        #1;
    endtask

    // Compare process
    initial begin
        exp_t ce;
        forever begin
            @(negedge clk);
            #2;
            if (bus.mem_req === 1'b1) n_req_seen++;
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) n_we_seen++;
            if (q.size() != 0) begin
                ce = q.pop_front();
                if (ce.chk_mem) begin
                    chk("mem_req", 32'(bus.mem_req), 32'(ce.req));
                    if (ce.req) begin
                        chk("mem_addr", 32'(bus.mem_addr), 32'(ce.addr));
                        chk("mem_we", 32'(bus.mem_we), 32'(ce.we));
                        if (ce.we) chk("mem_wdata", bus.mem_wdata, ce.wdata);
                    end
                    chk("E", 32'(bus.E), 32'(ce.e));
                    chk("misalign", 32'(bus.misalign), 32'(ce.mis));
                    chk("bus_err", 32'(bus.bus_err), 32'(ce.berr));
                end
                if (ce.chk_state) begin
                    chk("PC", bus.PC, ce.pc);
                    chk("I", bus.I, ce.i);
                    chk("ls_rdata", bus.ls_rdata, ce.rd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    // Driver
    initial begin
        int base_cnt;
        bus.next_pc = '0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_re = 1'b0;
        bus.ls_we = 1'b0; bus.jisr = 1'b0; bus.eret = 1'b0; bus.epc = '0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0;

        do_reset(1'b0);
        chk("lit_reset_pc", bus.PC, 32'h0);

        run_instr(mk(32'h2404_0006, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h4, 0));
        chk("lit_first_pc", bus.PC, 32'h4);
        chk("lit_first_I", bus.I, 32'h2404_0006);

        run_instr(mk(32'h8C02_0010, 1, 1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, 32'h0, 32'h8, 0));
        chk("lit_load_rdata", bus.ls_rdata, 32'hDEAD_BEEF);

        base_cnt = n_we_seen;
        run_instr(mk(32'hAC02_0008, 0, 1, 1, 32'h8, 32'h1234_5678, 32'h0000_0055, 0, 0, 0, 32'h0, 32'hC, 0));
        chk("lit_store_one_req", 32'(n_we_seen - base_cnt), 32'd1);
        chk("lit_store_keeps_rdata", bus.ls_rdata, 32'hDEAD_BEEF);

        base_cnt = n_req_seen;
        run_instr(mk(32'h8C02_0006, 0, 1, 0, 32'h6, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h10, 1));
        chk("lit_misalign_fetch_only", 32'(n_req_seen - base_cnt), 32'd1);
        chk("lit_misalign_pc", bus.PC, 32'h10);

        run_instr(mk(32'h0000_000C, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h40, 32'h14, 0));
        chk("lit_jisr_pc", bus.PC, 32'h80);

        run_instr(mk(32'h4200_0018, 2, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h40, 32'h84, 0));
        chk("lit_eret_pc", bus.PC, 32'h40);

        run_instr(mk(32'hAC02_0003, 0, 0, 1, 32'h3, 32'hFACE_FACE, 32'h0, 0, 0, 0, 32'h0, 32'h44, 0));
        run_instr(mk(32'h8C02_0000, 0, 1, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 32'h0, 32'h48, 0));
        chk("lit_load2_rdata", bus.ls_rdata, 32'hCAFE_F00D);

`ifdef MEM_ACCESS_TIMEOUT_EN
        run_instr(mk(32'h1234_0000, -1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h4C, 0));
        chk("lit_fetch_timeout_I", bus.I, 32'h0);
        run_instr(mk(32'h8C02_0020, 0, 1, 0, 32'h20, 32'h0, 32'h1111_2222, -1, 0, 0, 32'h0, 32'h50, 0));
        chk("lit_data_timeout_rdata", bus.ls_rdata, 32'hCAFE_F00D);
`endif

        // Reset in the middle of an unanswered fetch.
        for (int c = 0; c < 3; c++) begin
            exp_t e;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            e      = base_exp();
            e.req  = 1'b1;
            e.addr = m_pc[31:2];
            q.push_back(e);
        end
        do_reset(1'b1);
        chk("lit_midreset_pc", bus.PC, 32'h0);
        chk("lit_midreset_I", bus.I, 32'h0);

        run_instr(mk(32'h1111_1111, 2, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h4, 0));
        chk("lit_after_reset_pc", bus.PC, 32'h4);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
